// File: rtl/bitslam_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler and a scanned seven-segment driver.
// Optional macro BITSLAM_SEG_DECODE_EN enables the on-chip segment decoder.
module bitslam_bcd_counter #(
  parameter int PRESCALE = 1000,
  parameter int DIGITS   = 4,
  parameter int MUX_DIV  = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  tick,
  output logic                  carry_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            seg_out
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int SCAN_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(MUX_DIV - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [4*DIGITS-1:0] r_count;
  logic                r_tick;
  logic                r_carry;
  logic [SCAN_W-1:0]   r_scan;
  logic [DIGITS-1:0]   r_digitSel;

  logic                w_step;
  logic                w_chain;
  logic                w_wrap;
  logic [4*DIGITS-1:0] w_nextCount;
  logic [3:0]          w_nibble;

  assign w_step = enable && (r_pre == PRE_MAX);

  // Ripple a carry (up) or borrow (down) through the decades; a chain that
  // survives past the MSD means the whole counter wrapped.
  always_comb begin
    w_nextCount = r_count;
    w_chain     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_chain) begin
        if (up_down) begin
          if (r_count[4*i +: 4] == 4'd9) begin
            w_nextCount[4*i +: 4] = 4'd0;
          end else begin
            w_nextCount[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            w_chain               = 1'b0;
          end
        end else begin
          if (r_count[4*i +: 4] == 4'd0) begin
            w_nextCount[4*i +: 4] = 4'd9;
          end else begin
            w_nextCount[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            w_chain               = 1'b0;
          end
        end
      end
    end
    w_wrap = w_chain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (clear) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_step) begin
      r_pre   <= '0;
      r_count <= w_nextCount;
      r_tick  <= 1'b1;
      r_carry <= w_wrap;
    end else begin
      if (enable) begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end
  end

  // The scan runs freely so the display keeps refreshing through enable/clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan     <= '0;
      r_digitSel <= DIGITS'(1);
    end else if (r_scan == SCAN_MAX) begin
      r_scan     <= '0;
      r_digitSel <= (r_digitSel << 1) | (r_digitSel >> (DIGITS - 1));
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  always_comb begin
    w_nibble = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digitSel[i]) begin
        w_nibble = w_nibble | r_count[4*i +: 4];
      end
    end
  end

`ifdef BITSLAM_SEG_DECODE_EN
  always_comb begin
    case (w_nibble)
      4'd0:    seg_out = 7'b0111111;
      4'd1:    seg_out = 7'b0000110;
      4'd2:    seg_out = 7'b1011011;
      4'd3:    seg_out = 7'b1001111;
      4'd4:    seg_out = 7'b1100110;
      4'd5:    seg_out = 7'b1101101;
      4'd6:    seg_out = 7'b1111101;
      4'd7:    seg_out = 7'b0000111;
      4'd8:    seg_out = 7'b1111111;
      4'd9:    seg_out = 7'b1101111;
      default: seg_out = 7'b0000000;
    endcase
  end
`else
  assign seg_out = {3'b000, w_nibble};
`endif

  assign count_out = r_count;
  assign tick      = r_tick;
  assign carry_out = r_carry;
  assign digit_sel = r_digitSel;

endmodule

// File: tb/tb_bitslam_bcd_counter.sv
// Directed bench for bitslam_bcd_counter at PRESCALE=4, DIGITS=2, MUX_DIV=2;
// segment expectations follow whether BITSLAM_SEG_DECODE_EN is defined.
module tb_bitslam_bcd_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       upDown;
  logic       clear;
  logic [7:0] countOut;
  logic       tick;
  logic       carryOut;
  logic [1:0] digitSel;
  logic [6:0] segOut;

  int testsRun  = 0;
  int testsFail = 0;
  int edgeCount = 0;

  bitslam_bcd_counter #(
    .PRESCALE(4),
    .DIGITS(2),
    .MUX_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .up_down(upDown),
    .clear(clear),
    .count_out(countOut),
    .tick(tick),
    .carry_out(carryOut),
    .digit_sel(digitSel),
    .seg_out(segOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected segment pattern for a BCD digit in this build.
  function automatic logic [6:0] segFor(input logic [3:0] d);
`ifdef BITSLAM_SEG_DECODE_EN
    case (d)
      4'd0:    segFor = 7'b0111111;
      4'd1:    segFor = 7'b0000110;
      4'd2:    segFor = 7'b1011011;
      4'd3:    segFor = 7'b1001111;
      4'd4:    segFor = 7'b1100110;
      4'd5:    segFor = 7'b1101101;
      4'd6:    segFor = 7'b1111101;
      4'd7:    segFor = 7'b0000111;
      4'd8:    segFor = 7'b1111111;
      4'd9:    segFor = 7'b1101111;
      default: segFor = 7'b0000000;
    endcase
`else
    segFor = {3'b000, d};
`endif
  endfunction

  // Scan phase since reset: the one-hot advances after every second edge.
  function automatic logic [1:0] selFor(input int n);
    selFor = (((n / 2) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [7:0] toBcd(input int v);
    toBcd = {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic applyStimulus(input logic rst, input logic en, input logic ud, input logic clr);
    reset  = rst;
    enable = en;
    upDown = ud;
    clear  = clr;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edgeCount++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFail++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    advance(2);
    edgeCount = 0;
    checkOutput("rst_count", 32'(countOut), 32'h00);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_carry", 32'(carryOut), 32'd0);
    checkOutput("rst_sel", 32'(digitSel), 32'b01);
    checkOutput("rst_seg", 32'(segOut), 32'(segFor(4'd0)));

    // Steady up-count: one step per four edges, no wrap yet.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      advance(1);
      checkOutput("up_count", 32'(countOut), 32'(toBcd(k / 4)));
      checkOutput("up_tick", 32'(tick), 32'((k % 4) == 0));
      checkOutput("up_carry", 32'(carryOut), 32'd0);
    end
    checkOutput("up_sel", 32'(digitSel), 32'(selFor(edgeCount)));

    advance(356);
    checkOutput("pre_99", 32'(countOut), 32'h99);
    advance(4);
    checkOutput("wrap_count", 32'(countOut), 32'h00);
    checkOutput("wrap_tick", 32'(tick), 32'd1);
    checkOutput("wrap_carry", 32'(carryOut), 32'd1);
    advance(1);
    checkOutput("wrap_tick_end", 32'(tick), 32'd0);
    checkOutput("wrap_carry_end", 32'(carryOut), 32'd0);

    // Down-count from 0x00 with prescaler sitting at 1.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    advance(3);
    checkOutput("dn_wrap_count", 32'(countOut), 32'h99);
    checkOutput("dn_wrap_carry", 32'(carryOut), 32'd1);
    checkOutput("dn_wrap_tick", 32'(tick), 32'd1);
    advance(4);
    checkOutput("dn_98", 32'(countOut), 32'h98);
    checkOutput("dn_98_carry", 32'(carryOut), 32'd0);
    advance(352);
    checkOutput("dn_10", 32'(countOut), 32'h10);
    advance(4);
    checkOutput("dn_09", 32'(countOut), 32'h09);
    checkOutput("dn_09_carry", 32'(carryOut), 32'd0);

    // Freeze the prescaler at 2, then resume counting up.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    advance(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    advance(10);
    checkOutput("hold_count", 32'(countOut), 32'h09);
    checkOutput("hold_tick", 32'(tick), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    advance(1);
    checkOutput("resume1_count", 32'(countOut), 32'h09);
    advance(1);
    checkOutput("resume2_count", 32'(countOut), 32'h10);
    checkOutput("resume2_tick", 32'(tick), 32'd1);

    // Clear on a step edge wins over the step.
    advance(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    advance(1);
    checkOutput("clr_count", 32'(countOut), 32'h00);
    checkOutput("clr_tick", 32'(tick), 32'd0);
    checkOutput("clr_carry", 32'(carryOut), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    advance(3);
    checkOutput("clr_pre_zero", 32'(countOut), 32'h00);
    advance(1);
    checkOutput("clr_first_step", 32'(countOut), 32'h01);

    // Hold at 0x37 and watch the scan.
    advance(144);
    checkOutput("disp_count", 32'(countOut), 32'h37);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      advance(1);
      checkOutput("disp_sel", 32'(digitSel), 32'(selFor(edgeCount)));
      checkOutput("disp_seg", 32'(segOut),
                  32'((selFor(edgeCount) == 2'b01) ? segFor(4'd7) : segFor(4'd3)));
    end

    // Count down to 0x25, park prescaler at 3, then reset mid-period.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    advance(48);
    checkOutput("pre_rst_count", 32'(countOut), 32'h25);
    advance(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    advance(1);
    edgeCount = 0;
    checkOutput("mid_rst_count", 32'(countOut), 32'h00);
    checkOutput("mid_rst_tick", 32'(tick), 32'd0);
    checkOutput("mid_rst_sel", 32'(digitSel), 32'b01);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    advance(3);
    checkOutput("post_rst_3", 32'(countOut), 32'h00);
    advance(1);
    checkOutput("post_rst_4", 32'(countOut), 32'h01);
    checkOutput("post_rst_tick", 32'(tick), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/bitslam_bcd_counter.md
# bitslam_bcd_counter

Parametrised multi-digit BCD event/seconds counter with prescaler, up/down counting, synchronous clear and a scanned seven-segment display driver. It generalises the single-digit 0–9 prescaled counter to DIGITS cascaded decades with carry/borrow, and adds display multiplexing. It sits behind the top-level 8-bit pin wrapper, which drives clk from io_in[0] and reset from io_in[1] and routes seg_out and digit_sel to io_out.

## Interface
Parameters:
- PRESCALE, 1000: clk cycles per count step; legal range ≥ 2. At 1000 Hz clk this is one step per second.
- DIGITS, 4: number of BCD decades; legal range 1–8.
- MUX_DIV, 250: clk cycles each digit is shown during the display scan; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- enable  input  1  high: prescaler runs; low: prescaler and count hold.
- up_down  input  1  1 = count up, 0 = count down; sampled on the step edge.
- clear  input  1  synchronous; zeroes the prescaler and the count; the display scan is unaffected.
- count_out  output  4*DIGITS  BCD value; decade 0 (LSD) is in bits [3:0].
- tick  output  1  one-cycle pulse, high in the first cycle a new count value is visible.
- carry_out  output  1  one-cycle pulse, coincident with tick, on full wrap (up: all 9s→0; down: all 0s→all 9s).
- digit_sel  output  DIGITS  one-hot, active-high select of the digit currently displayed.
- seg_out  output  7  segment pattern {g,f,e,d,c,b,a}, active-high, for the selected digit.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1, advancing only while enable=1.
- When enable=1 and pre==PRESCALE-1:
  - pre←0;
  - the count steps once in the direction given by up_down;
  - tick←1 on the next cycle.
- Up step: decade 0 increments. A decade at 9 becomes 0 and carries into the next decade. If every decade is 9, the result is all 0 and carry_out←1.
- Down step: decade 0 decrements. A decade at 0 becomes 9 and borrows from the next decade. If every decade is 0, the result is all 9 and carry_out←1.
- Priority: reset > clear > step.
  - clear forces pre←0 and count←0, and suppresses tick/carry_out for that edge.
  - clear does not touch the scan counter.
- Display scan:
  - The scan counter counts 0..MUX_DIV-1 continuously; enable and clear have no effect on it.
  - On wrap, digit_sel rotates left one-hot (LSD→MSD, then back to LSD).
  - seg_out decodes the selected decade combinationally from the registered count and digit_sel.
- Decode patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Codes 10–15 cannot occur and decode to 0000000.

## Timing
- Reset values:
  - count_out=0, tick=0, carry_out=0;
  - pre=0, scan counter=0;
  - digit_sel=1 (LSD);
  - seg_out=0111111 with BITSLAM_SEG_DECODE_EN defined, 0000000 without.
- Step latency: the count changes on the edge at which pre==PRESCALE-1 is sampled with enable=1.
  - tick and carry_out are high for exactly the following cycle.
- Steady enable: one step every PRESCALE cycles; the first step comes PRESCALE edges after reset is released.
- Mid-period behaviour:
  - Deasserting enable freezes pre; reasserting enable resumes from the frozen value, with no lost or extra steps.
  - up_down changes mid-period take effect at the next step.
- clear with enable=1 on the step edge: the result is count=0, and tick stays low.
- Scan: digit_sel holds each one-hot value for exactly MUX_DIV cycles. seg_out follows digit_sel and count_out in the same cycle.

## Configuration
- Macro: BITSLAM_SEG_DECODE_EN.
- Defined: seg_out is the seven-segment decode of the selected digit, as described above.
- Undefined:
  - The decoder is omitted; seg_out = {3'b000, selected BCD nibble}.
  - digit_sel and the scan counter are unchanged.
  - Intended for use with an external decoder IC.

## Test plan
Bench parameters: PRESCALE=4, DIGITS=2, MUX_DIV=2, macro defined unless stated.
- Reset, then enable=1 and up_down=1 for 40 cycles → count_out steps 0x00, 0x01, … every 4 cycles; tick pulses every 4th cycle; value 0x10 is reached after 40 edges, with no carry_out.
- Preload to 0x99 by counting up → next step gives 0x00 with tick=1 and carry_out=1 in the same single cycle.
- From 0x00 with up_down=0 → one step gives 0x99 and carry_out=1. A further step gives 0x98; from 0x10 a step gives 0x09.
- enable toggled low at pre=2 for 10 cycles, then high → the next step occurs 2 cycles after re-enable. clear asserted on a step edge → count 0x00, tick stays 0.
- Display at count 0x37 → digit_sel alternates 01/10 every 2 cycles, with seg_out 0000111 ("7") when digit_sel=01 and 1001111 ("3") when digit_sel=10. With the macro undefined → seg_out 0000111 then 0000011.
- reset asserted mid-count at 0x25 with pre=3 → the next cycle shows count 0x00, tick 0, digit_sel 01. The first step comes 4 edges after reset is released.
